// File: rtl/race_turn_controller.sv
// Two-player board race turn sequencer: accepts colour rolls, animates moves one square per STEP_TICKS cycles.
// Optional macro RACE_EXACT_FINISH_EN rejects rolls that would overshoot the finish square.
module race_turn_controller #(
  parameter int BOARD_LEN  = 16,
  parameter int STEP_TICKS = 25_000_000,
  parameter int PW         = $clog2(BOARD_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_game,
  input  logic          result_ready,
  input  logic [1:0]    movement_steps,
  output logic [PW-1:0] pos_p0,
  output logic [PW-1:0] pos_p1,
  output logic          cur_player,
  output logic          busy,
  output logic          step_pulse,
  output logic          game_over,
  output logic          winner
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] LAST_SQ   = PW'(BOARD_LEN - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_ROLL, MOVE, NEXT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos0_q, pos0_d;
  logic [PW-1:0] pos1_q, pos1_d;
  logic          cur_q, cur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    rem_q, rem_d;
  logic          start_prev_q, start_prev_d;
  logic          rdy_prev_q, rdy_prev_d;
  logic          busy_q, busy_d;
  logic          step_pulse_q, step_pulse_d;
  logic          game_over_q, game_over_d;
  logic          winner_q, winner_d;

  logic          start_edge;
  logic          roll_edge;
  logic          roll_fits;
  logic [PW-1:0] cur_pos;
  logic [PW-1:0] next_pos;

  assign start_edge = start_game & ~start_prev_q;
  assign roll_edge  = result_ready & ~rdy_prev_q;
  assign cur_pos    = cur_q ? pos1_q : pos0_q;
  assign next_pos   = (cur_pos == LAST_SQ) ? cur_pos : cur_pos + 1'b1;

`ifdef RACE_EXACT_FINISH_EN
  logic [PW+1:0] roll_sum;
  assign roll_sum  = (PW+2)'(cur_pos) + (PW+2)'(movement_steps);
  assign roll_fits = (roll_sum <= (PW+2)'(BOARD_LEN - 1));
`else
  assign roll_fits = 1'b1;
`endif

  // A start edge overrides everything else, including a simultaneous roll edge.
  always_comb begin
    state_d      = state_q;
    pos0_d       = pos0_q;
    pos1_d       = pos1_q;
    cur_d        = cur_q;
    tick_d       = tick_q;
    rem_d        = rem_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    step_pulse_d = 1'b0;
    start_prev_d = start_game;
    rdy_prev_d   = result_ready;

    if (start_edge) begin
      state_d     = WAIT_ROLL;
      pos0_d      = '0;
      pos1_d      = '0;
      cur_d       = 1'b0;
      tick_d      = '0;
      rem_d       = '0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_ROLL: begin
          if (roll_edge && (movement_steps != 2'd0) && roll_fits) begin
            rem_d   = movement_steps;
            tick_d  = '0;
            state_d = MOVE;
          end
        end
        MOVE: begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            step_pulse_d = 1'b1;
            rem_d        = rem_q - 2'd1;
            if (cur_q) pos1_d = next_pos;
            else       pos0_d = next_pos;
            // Reaching the finish ends the game even with steps left over.
            if (next_pos == LAST_SQ) begin
              state_d     = DONE;
              rem_d       = '0;
              game_over_d = 1'b1;
              winner_d    = cur_q;
            end else if (rem_q == 2'd1) begin
              state_d = NEXT;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        NEXT: begin
          cur_d   = ~cur_q;
          state_d = WAIT_ROLL;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == MOVE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pos0_q       <= '0;
      pos1_q       <= '0;
      cur_q        <= 1'b0;
      tick_q       <= '0;
      rem_q        <= '0;
      start_prev_q <= 1'b0;
      rdy_prev_q   <= 1'b0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos0_q       <= pos0_d;
      pos1_q       <= pos1_d;
      cur_q        <= cur_d;
      tick_q       <= tick_d;
      rem_q        <= rem_d;
      start_prev_q <= start_prev_d;
      rdy_prev_q   <= rdy_prev_d;
      busy_q       <= busy_d;
      step_pulse_q <= step_pulse_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign pos_p0     = pos0_q;
  assign pos_p1     = pos1_q;
  assign cur_player = cur_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule
